pc_checkpoint_monitor: RTL and testbench
========================================

PC_CHECKPOINT_MONITOR -- requirements
Module: pc_checkpoint_monitor

Interface
REQ-001 Parameter PC_W, default 32, width of the monitored PC.
REQ-002 Parameter N_CHK, default 8, number of checkpoint entries; legal range 1..64.
REQ-003 Parameter TIMEOUT_CYC, default 4096, maximum cycles allowed between checkpoint hits.
REQ-004 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port pc  in  PC_W  CPU program counter, sampled every rising edge.
REQ-007 Port start  in  1  arms the monitor (IDLE or a terminal state -> RUN).
REQ-008 Port clear  in  1  returns the monitor to IDLE; table contents are kept.
REQ-009 Port cfg_we  in  1  checkpoint table write strobe.
REQ-010 Port cfg_idx  in  $clog2(N_CHK)  entry written.
REQ-011 Port cfg_pass_pc / cfg_fail_pc  in  PC_W each  expected PC and forbidden PC of the entry.
REQ-012 Port cfg_last  in  1  marks the entry as the final checkpoint.
REQ-013 Port busy  out  1  high in RUN.
REQ-014 Port passed / failed / timed_out  out  1 each  terminal status flags; at most one is high.
REQ-015 Port hit  out  1  one-cycle pulse per checkpoint passed.
REQ-016 Port pass_count  out  $clog2(N_CHK+1)  checkpoints passed since start.
REQ-017 Port fail_idx  out  $clog2(N_CHK)  entry index at failure or timeout.

Function
REQ-018 States SHALL be IDLE, RUN, PASS, FAIL and TMO; all outputs SHALL be registered and appear the cycle after the sampling edge.
REQ-019 A table write SHALL occur only when cfg_we is high in IDLE; it sets the entry's valid bit, and writes in other states SHALL be ignored.
REQ-020 start in IDLE/PASS/FAIL/TMO SHALL enter RUN with current index k=0, pass_count=0, fail_idx=0, timeout counter=0, and all flags clear.
REQ-021 In RUN, if pc equals fail_pc[k], the state SHALL become FAIL with fail_idx=k.
REQ-022 In RUN, otherwise if pc equals pass_pc[k], then hit SHALL pulse, pass_count SHALL increment and k SHALL increment.
REQ-023 If pc equals both pass_pc[k] and fail_pc[k] on the same edge, fail SHALL win.
REQ-024 Only entry k SHALL be compared on any edge; matches against other entries SHALL be ignored.
REQ-025 A pass on an entry with last=1, or on entry N_CHK-1, SHALL enter PASS.
REQ-026 Reaching an index k whose valid bit is 0 SHALL enter PASS on the next edge without a hit.
REQ-027 The timeout counter SHALL clear on each hit, otherwise increment in RUN.
REQ-028 When the timeout counter reaches TIMEOUT_CYC-1 without a hit, the state SHALL become TMO with fail_idx=k.
REQ-029 clear SHALL take priority over start; start SHALL take priority over the RUN comparison.
REQ-030 PASS, FAIL and TMO SHALL hold until start, clear or reset.

Reset
REQ-031 reset SHALL force IDLE, busy=0, passed=0, failed=0, timed_out=0, hit=0, pass_count=0, fail_idx=0, k=0, and timeout counter=0.
REQ-032 reset SHALL clear every table entry to all zeros including the valid and last bits; reset during RUN SHALL abandon the run with no flag set.

Structure
REQ-033 The state enumeration and the default values of PC_W, N_CHK and TIMEOUT_CYC SHALL live in package pc_mon_pkg.
REQ-034 The checkpoint storage (pass_pc, fail_pc, last, valid with one write port and a read at index k) SHALL be sub-module pc_mon_table.

Verification
REQ-035 Load entries (12,16), (32,28), (48,44,last), start, drive pc 0,4,8,12,20,24,32,36,40,48 -> hit on 12, 32 and 48; passed=1 and pass_count=3.
REQ-036 Same table, pc sequence 0,4,8,12,20,24,28 -> failed=1, fail_idx=1, pass_count=1.
REQ-037 Entry 0 pass=fail=60, pc=60 -> failed=1, fail_idx=0, no hit.
REQ-038 TIMEOUT_CYC=16, entry 0 pass=100, pc held at 4 -> timed_out=1 on the 16th RUN cycle, fail_idx=0.
REQ-039 Only entries 0 and 1 valid (72, 92), both hit -> passed=1 with pass_count=2; a cfg_we during RUN leaves the table unchanged.
REQ-040 Assert reset in RUN after 1 hit -> all outputs zero next cycle; start then yields pass_count=0 with an empty table -> passed=1.

Source files
------------

// File: rtl/pc_mon_pkg.sv
// Shared types and defaults for the PC checkpoint monitor.
// Imported by the monitor top and its checkpoint table.
package pc_mon_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int N_CHK_DEF   = 8;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

endpackage

// File: rtl/pc_mon_table.sv
// Checkpoint storage: one write port, one combinational read port.
// Reset wipes every entry, including its valid and last bits.
module pc_mon_table #(
    parameter int PC_W  = 32,
    parameter int N_CHK = 8,
    parameter int IW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [IW-1:0]   widx,
    input  logic [PC_W-1:0] wpass,
    input  logic [PC_W-1:0] wfail,
    input  logic            wlast,
    input  logic [IW-1:0]   ridx,
    output logic [PC_W-1:0] rpass,
    output logic [PC_W-1:0] rfail,
    output logic            rlast,
    output logic            rvalid
);

    logic [PC_W-1:0]  pass_q [N_CHK];
    logic [PC_W-1:0]  fail_q [N_CHK];
    logic [N_CHK-1:0] last_q;
    logic [N_CHK-1:0] valid_q;

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = we && (int'(widx) < N_CHK);
    assign rd_ok = int'(ridx) < N_CHK;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHK; i++) begin
                pass_q[i] <= '0;
                fail_q[i] <= '0;
            end
            last_q  <= '0;
            valid_q <= '0;
        end else if (wr_ok) begin
            pass_q[widx]  <= wpass;
            fail_q[widx]  <= wfail;
            last_q[widx]  <= wlast;
            valid_q[widx] <= 1'b1;
        end
    end

    assign rpass  = rd_ok ? pass_q[ridx]  : '0;
    assign rfail  = rd_ok ? fail_q[ridx]  : '0;
    assign rlast  = rd_ok ? last_q[ridx]  : 1'b0;
    assign rvalid = rd_ok ? valid_q[ridx] : 1'b0;

endmodule

// File: rtl/pc_checkpoint_monitor.sv
// Walks an ordered checkpoint table against the live PC and reports
// pass, fail or timeout; only the current entry k is ever compared.
module pc_checkpoint_monitor
    import pc_mon_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int N_CHK       = N_CHK_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    localparam int IW = (N_CHK > 1) ? $clog2(N_CHK) : 1,
    localparam int CW = $clog2(N_CHK + 1),
    localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    input  logic            start,
    input  logic            clear,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [PC_W-1:0] cfg_pass_pc,
    input  logic [PC_W-1:0] cfg_fail_pc,
    input  logic            cfg_last,
    output logic            busy,
    output logic            passed,
    output logic            failed,
    output logic            timed_out,
    output logic            hit,
    output logic [CW-1:0]   pass_count,
    output logic [IW-1:0]   fail_idx
);

    state_t          state;
    logic [IW-1:0]   k;
    logic [TW-1:0]   tcnt;
    logic [PC_W-1:0] e_pass;
    logic [PC_W-1:0] e_fail;
    logic            e_last;
    logic            e_valid;
    logic            final_chk;

    pc_mon_table #(
        .PC_W  (PC_W),
        .N_CHK (N_CHK),
        .IW    (IW)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (cfg_we && (state == S_IDLE)),
        .widx   (cfg_idx),
        .wpass  (cfg_pass_pc),
        .wfail  (cfg_fail_pc),
        .wlast  (cfg_last),
        .ridx   (k),
        .rpass  (e_pass),
        .rfail  (e_fail),
        .rlast  (e_last),
        .rvalid (e_valid)
    );

    assign final_chk = e_last || (int'(k) == N_CHK - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            passed     <= 1'b0;
            failed     <= 1'b0;
            timed_out  <= 1'b0;
            hit        <= 1'b0;
            pass_count <= '0;
            fail_idx   <= '0;
            k          <= '0;
            tcnt       <= '0;
        end else begin
            hit <= 1'b0;
            if (clear || start) begin
                state      <= clear ? S_IDLE : S_RUN;
                busy       <= !clear;
                passed     <= 1'b0;
                failed     <= 1'b0;
                timed_out  <= 1'b0;
                pass_count <= '0;
                fail_idx   <= '0;
                k          <= '0;
                tcnt       <= '0;
            end else if (state == S_RUN) begin
                // fail beats pass on the same entry; timeout only if neither
                if (!e_valid) begin
                    state  <= S_PASS;
                    busy   <= 1'b0;
                    passed <= 1'b1;
                end else if (pc == e_fail) begin
                    state    <= S_FAIL;
                    busy     <= 1'b0;
                    failed   <= 1'b1;
                    fail_idx <= k;
                end else if (pc == e_pass) begin
                    hit        <= 1'b1;
                    pass_count <= pass_count + CW'(1);
                    tcnt       <= '0;
                    if (final_chk) begin
                        state  <= S_PASS;
                        busy   <= 1'b0;
                        passed <= 1'b1;
                    end else begin
                        k <= k + IW'(1);
                    end
                end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state     <= S_TMO;
                    busy      <= 1'b0;
                    timed_out <= 1'b1;
                    fail_idx  <= k;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_checkpoint_monitor.sv
// Scoreboard bench: each driven cycle queues its expected outputs,
// a monitor pops and compares them just after the sampling edge.
module tb_pc_checkpoint_monitor;

    typedef struct packed {
        logic       busy;
        logic       passed;
        logic       failed;
        logic       tmo;
        logic       hit;
        logic [3:0] cnt;
        logic [2:0] fidx;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [31:0] cfg_pass_pc = '0;
    logic [31:0] cfg_fail_pc = '0;
    logic        cfg_last = 1'b0;
    logic        busy;
    logic        passed;
    logic        failed;
    logic        timed_out;
    logic        hit;
    logic [3:0]  pass_count;
    logic [2:0]  fail_idx;

    obs_t  q[$];
    string tq[$];
    string tag = "init";
    int    n_chk = 0;
    int    n_pass = 0;

    pc_checkpoint_monitor #(
        .PC_W        (32),
        .N_CHK       (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .start       (start),
        .clear       (clear),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_pass_pc (cfg_pass_pc),
        .cfg_fail_pc (cfg_fail_pc),
        .cfg_last    (cfg_last),
        .busy        (busy),
        .passed      (passed),
        .failed      (failed),
        .timed_out   (timed_out),
        .hit         (hit),
        .pass_count  (pass_count),
        .fail_idx    (fail_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", t, got, exp);
    endtask

    function automatic obs_t mk(bit b, bit p, bit f, bit t, bit h, int c, int fi);
        obs_t o;
        o.busy   = b;
        o.passed = p;
        o.failed = f;
        o.tmo    = t;
        o.hit    = h;
        o.cnt    = 4'(c);
        o.fidx   = 3'(fi);
        return o;
    endfunction

    initial begin
        obs_t  e;
        obs_t  o;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                t = tq.pop_front();
                o = {busy, passed, failed, timed_out, hit, pass_count, fail_idx};
                chk(t, 32'(o), 32'(e));
            end
        end
    end

    task automatic cyc(input logic [31:0] p, input obs_t e);
        pc = p;
        q.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int idx, input int pp, input int fp, input bit last);
        cfg_we      = 1'b1;
        cfg_idx     = 3'(idx);
        cfg_pass_pc = 32'(pp);
        cfg_fail_pc = 32'(fp);
        cfg_last    = last;
        @(posedge clk);
        #2;
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc(32'd0, mk(1, 0, 0, 0, 0, 0, 0));
        start = 1'b0;
    endtask

    task automatic rst();
        reset = 1'b1;
        cyc(32'd0, mk(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] pcs [10];
        bit          hv  [10];
        int          c;
        bit          last;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pcs [10];
        bit          hv  [10];
        int          c;
        bit          last;

        tag = "reset";
        rst();
        rst();

        wr(0, 12, 16, 0);
        wr(1, 32, 28, 0);
        wr(2, 48, 44, 1);

        tag = "seq_pass";
        go();
        pcs = '{0, 4, 8, 12, 20, 24, 32, 36, 40, 48};
        hv  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        c = 0;
        for (int i = 0; i < 10; i++) begin
            if (hv[i]) c++;
            last = (i == 9);
            cyc(pcs[i], mk(!last, last, 0, 0, hv[i], c, 0));
        end
        tag = "pass_hold";
        cyc(32'd12, mk(0, 1, 0, 0, 0, 3, 0));

        tag = "seq_fail";
        go();
        pcs = '{0, 4, 8, 12, 20, 24, 0, 0, 0, 0};
        c = 0;
        for (int i = 0; i < 6; i++) begin
            if (pcs[i] == 32'd12) c++;
            cyc(pcs[i], mk(1, 0, 0, 0, pcs[i] == 32'd12, c, 0));
        end
        cyc(32'd28, mk(0, 0, 1, 0, 0, 1, 1));
        tag = "fail_hold";
        cyc(32'd32, mk(0, 0, 1, 0, 0, 1, 1));

        tag = "clear_over_start";
        clear = 1'b1;
        start = 1'b1;
        cyc(32'd0, mk(0, 0, 0, 0, 0, 0, 0));
        clear = 1'b0;
        start = 1'b0;

        wr(0, 60, 60, 0);
        tag = "fail_wins";
        go();
        cyc(32'd60, mk(0, 0, 1, 0, 0, 0, 0));

        tag = "clear";
        clear = 1'b1;
        cyc(32'd0, mk(0, 0, 0, 0, 0, 0, 0));
        clear = 1'b0;
        wr(0, 100, 200, 0);
        tag = "timeout";
        go();
        for (int i = 1; i < 16; i++) cyc(32'd4, mk(1, 0, 0, 0, 0, 0, 0));
        cyc(32'd4, mk(0, 0, 0, 1, 0, 0, 0));
        tag = "tmo_hold";
        cyc(32'd100, mk(0, 0, 0, 1, 0, 0, 0));

        tag = "reset2";
        rst();
        wr(0, 72, 300, 0);
        wr(1, 92, 300, 0);
        tag = "invalid_end";
        go();
        cfg_we      = 1'b1;
        cfg_idx     = 3'd2;
        cfg_pass_pc = 32'd100;
        cfg_fail_pc = 32'd300;
        cyc(32'd0, mk(1, 0, 0, 0, 0, 0, 0));
        cfg_we = 1'b0;
        cyc(32'd72, mk(1, 0, 0, 0, 1, 1, 0));
        cyc(32'd92, mk(1, 0, 0, 0, 1, 2, 0));
        cyc(32'd100, mk(0, 1, 0, 0, 0, 2, 0));

        tag = "reset_in_run";
        go();
        cyc(32'd72, mk(1, 0, 0, 0, 1, 1, 0));
        rst();
        tag = "empty_table";
        go();
        cyc(32'd72, mk(0, 1, 0, 0, 0, 0, 0));

        chk("drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
